note_player: RTL and testbench
==============================

# note_player

Plays back a 160-slot transcription (the same `[159:0][5:0]` note array the recorder fills and the sprite renderer draws) as an 8-bit signed audio stream. It steps through the slots at one slot per eighth note and synthesizes a sine tone at each slot's pitch using a phase accumulator. New samples are produced on the shared audio sample tick. The output feeds `volume_control` and then the PDM/PWM speaker path as another selectable audio source.

## Interface
Parameters:
- `NUM_SLOTS`, 160: number of note slots in `notes_in`.
- `NOTE_W`, 6: bits per note index.
- `EIGHTH_CYCLES`, 34816000: clock cycles per slot (0.5 s at 69.632 MHz).
- `PHASE_W`, 16: phase accumulator width.

Ports:
- `clk_in`, in, 1: system clock (clk_m domain).
- `rst_in`, in, 1: reset. One clock; reset is synchronous and active-high.
- `notes_in`, in, `[NUM_SLOTS-1:0][NOTE_W-1:0]`: note array.
  - 0 = rest.
  - 1..47 = semitone index into `PHASE_INC`.
  - Values ≥ 48 are treated as rest.
- `start_in`, in, 1: single-cycle pulse that begins playback at slot 0.
- `stop_in`, in, 1: single-cycle pulse that aborts playback.
- `loop_in`, in, 1: level input. When high, the last slot wraps to slot 0 instead of finishing.
- `tick_in`, in, 1: single-cycle sample-step strobe (~8.47 kHz).
- `amp_out`, out, 8, signed: current sample.
- `amp_valid_out`, out, 1: pulses when `amp_out` updates.
- `playing_out`, out, 1: high while in PLAY.
- `slot_out`, out, 8: index of the slot currently sounding.
- `done_out`, out, 1: single-cycle pulse when playback ends naturally.

## Operation
State machine with states IDLE and PLAY.
- **IDLE**
  - On `start_in`: enter PLAY.
  - Set `slot` = 0 and `cyc` = 0.
  - Latch `cur_note` ← `notes_in[0]` and set `phase` = 0.
- **PLAY**
  - `cyc` increments every cycle.
  - When `cyc == EIGHTH_CYCLES-1`: set `cyc` ← 0.
    - If `slot < NUM_SLOTS-1`: `slot` ← `slot+1` and latch `cur_note` ← `notes_in[slot+1]`.
    - Else, if `loop_in` is high: `slot` ← 0 and latch `cur_note` ← `notes_in[0]`.
    - Else: go to IDLE and pulse `done_out`.
  - When the newly latched note differs from the old `cur_note`, `phase` resets to 0. Equal consecutive notes are legato: phase continues.
- **Sample generation** on `tick_in`, in PLAY only:
  - `phase` ← `phase + PHASE_INC[cur_note]`.
  - Sample = `SINE_LUT[phase[PHASE_W-1 -: 6]]`, using the pre-increment phase.
  - For a rest or an out-of-range note, the sample is 0 and `phase` is held.
  - In IDLE, `tick_in` still produces `amp_valid_out` with `amp_out` = 0.
- **Stop**
  - `stop_in` in PLAY: go to IDLE, `amp_out` ← 0 next cycle, no `done_out`.
  - `stop_in` in IDLE is ignored.
- **Simultaneous and boundary events**
  - `stop_in` and `start_in` together: stop wins and the block stays or returns to IDLE.
  - `start_in` in PLAY: restart at slot 0 (same actions as the IDLE transition).
  - `tick_in` on the slot-boundary cycle uses the old `cur_note`; the new note applies to later ticks.
  - `notes_in` changes mid-slot have no effect until the next slot latch.
- **Arithmetic**: phase wraps modulo 2^PHASE_W. LUT entries are signed 8-bit, range −127..127.

## Timing
- **Reset values**: `amp_out` = 0, `amp_valid_out` = 0, `playing_out` = 0, `slot_out` = 0, `done_out` = 0. Reset also sets `phase` = 0, `cyc` = 0, `cur_note` = 0 and forces state IDLE.
- Reset asserted mid-playback takes effect on the next edge, with no `done_out`.
- **Latency**: `tick_in` in cycle t produces `amp_valid_out` = 1 and a new `amp_out` in cycle t+2.
  - t+1: registered LUT read.
  - t+2: output register.
- `amp_out` holds its value between valid pulses.
- `playing_out` and `slot_out` are registered and reflect state from the cycle after the transition.
  - `start_in` in cycle t gives `playing_out` = 1 at t+1.
- `done_out` is high in the same cycle `playing_out` falls.
- Each slot lasts exactly `EIGHTH_CYCLES` cycles. A non-looped song lasts `NUM_SLOTS×EIGHTH_CYCLES` cycles from start to `done_out`.

## Structure
- Package `note_pkg` holds:
  - `localparam NUM_PITCHES = 48`.
  - `PHASE_INC[48]`: 16-bit increments for 8467 Hz sampling, with semitone 1 = C3. `PHASE_INC[0]` = 0.
  - `SINE_LUT[64]`: signed 8-bit full-wave table.
  - `typedef enum logic {IDLE, PLAY} player_state_t`.
- The recorder and `note_lookup` share `note_pkg` so that note indices agree across blocks.
- One sub-module, `sine_rom`: a registered 6-bit-address, 8-bit-data ROM initialized from `SINE_LUT`.

## Test plan
Use `EIGHTH_CYCLES` = 10 and `NUM_SLOTS` = 4 unless stated otherwise.
- **Reset**: hold `rst_in`, then apply ticks → all outputs 0 and `amp_valid_out` never high during reset.
- **Single note**: notes {1,1,1,1}, start, tick every 3 cycles → `amp_out` sequence matches `SINE_LUT[(k·PHASE_INC[1])>>10]`, each sample 2 cycles after its tick. Phase never resets at slot boundaries. `done_out` pulses 40 cycles after `playing_out` rises.
- **Rest and out-of-range**: notes {0,50,2,0} → `amp_out` = 0 in slots 0, 1 and 3. Slot 2 starts from phase 0, so its first sample is `SINE_LUT[0]`.
- **Loop and stop**: `loop_in` = 1 → `slot_out` goes 3→0 with no `done_out`. `stop_in` in slot 2 → `playing_out` = 0 next cycle, later `amp_out` = 0, no `done_out`.
- **Simultaneous events**:
  - `start_in` and `stop_in` together → stays IDLE.
  - `start_in` in slot 2 → `slot_out` = 0 and `cyc` restarts.
  - Tick on a boundary cycle → sample uses the old note.
- **Full length**: defaults with `EIGHTH_CYCLES` = 4 → 160 slots, `done_out` at exactly 640 cycles, `slot_out` reaches 159.

Source files
------------

// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - pitch increments, sine table and player state shared by note blocks
package note_pkg;

   localparam int NUM_PITCHES = 48;

   // Phase increments for 8467 Hz sampling, index 1 = C3; index 0 is a rest
   localparam logic [15:0] PHASE_INC [NUM_PITCHES] = '{
      16'd0,
      16'd1013,  16'd1073,  16'd1137,  16'd1204,  16'd1276,  16'd1352,
      16'd1432,  16'd1517,  16'd1607,  16'd1703,  16'd1804,  16'd1911,
      16'd2025,  16'd2145,  16'd2273,  16'd2408,  16'd2551,  16'd2703,
      16'd2864,  16'd3034,  16'd3215,  16'd3406,  16'd3608,  16'd3823,
      16'd4050,  16'd4291,  16'd4546,  16'd4816,  16'd5103,  16'd5406,
      16'd5728,  16'd6068,  16'd6429,  16'd6811,  16'd7216,  16'd7645,
      16'd8100,  16'd8582,  16'd9092,  16'd9633,  16'd10205, 16'd10812,
      16'd11455, 16'd12136, 16'd12858, 16'd13623, 16'd14433
   };

   localparam logic signed [7:0] SINE_LUT [64] = '{
       8'sd0,    8'sd12,   8'sd25,   8'sd37,   8'sd49,   8'sd60,   8'sd71,   8'sd81,
       8'sd90,   8'sd98,   8'sd106,  8'sd112,  8'sd117,  8'sd122,  8'sd125,  8'sd126,
       8'sd127,  8'sd126,  8'sd125,  8'sd122,  8'sd117,  8'sd112,  8'sd106,  8'sd98,
       8'sd90,   8'sd81,   8'sd71,   8'sd60,   8'sd49,   8'sd37,   8'sd25,   8'sd12,
       8'sd0,   -8'sd12,  -8'sd25,  -8'sd37,  -8'sd49,  -8'sd60,  -8'sd71,  -8'sd81,
      -8'sd90,  -8'sd98,  -8'sd106, -8'sd112, -8'sd117, -8'sd122, -8'sd125, -8'sd126,
      -8'sd127, -8'sd126, -8'sd125, -8'sd122, -8'sd117, -8'sd112, -8'sd106, -8'sd98,
      -8'sd90,  -8'sd81,  -8'sd71,  -8'sd60,  -8'sd49,  -8'sd37,  -8'sd25,  -8'sd12
   };

   typedef enum logic {IDLE, PLAY} player_state_t;

endpackage

// File: rtl/sine_rom.sv
// rtl/sine_rom.sv - registered 64-entry sine table read
module sine_rom
   import note_pkg::*;
(
   input  logic              clk_i,
   input  logic [5:0]        addr_i,
   output logic signed [7:0] data_o
);

   logic signed [7:0] data_q;

   always_ff @(posedge clk_i) begin
      data_q <= SINE_LUT[addr_i];
   end

   assign data_o = data_q;

endmodule

// File: rtl/note_player.sv
// rtl/note_player.sv - steps through a note transcription and synthesizes a sine tone per slot
module note_player
   import note_pkg::*;
#(
   parameter int NUM_SLOTS     = 160,
   parameter int NOTE_W        = 6,
   parameter int EIGHTH_CYCLES = 34816000,
   parameter int PHASE_W       = 16
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic [NUM_SLOTS-1:0][NOTE_W-1:0] notes_in,
   input  logic                             start_in,
   input  logic                             stop_in,
   input  logic                             loop_in,
   input  logic                             tick_in,
   output logic signed [7:0]                amp_out,
   output logic                             amp_valid_out,
   output logic                             playing_out,
   output logic [7:0]                       slot_out,
   output logic                             done_out
);

   localparam int               CYC_W     = $clog2(EIGHTH_CYCLES + 1);
   localparam int               IDX_W     = $clog2(NUM_SLOTS);
   localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(EIGHTH_CYCLES - 1);
   localparam logic [7:0]       SLOT_LAST = 8'(NUM_SLOTS - 1);

   player_state_t      state_q, state_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [7:0]         slot_q, slot_d;
   logic [NOTE_W-1:0]  note_q, note_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic               done_q, done_d;
   logic               tick_q, mute_q, mute_d;
   logic signed [7:0]  amp_q, amp_d;
   logic               valid_q, valid_d;

   logic signed [7:0]  rom_data;
   logic               note_ok;
   logic [PHASE_W-1:0] inc;
   logic               latch;
   logic [NOTE_W-1:0]  latch_note;

   sine_rom u_rom (
      .clk_i  (clk_in),
      .addr_i (phase_q[PHASE_W-1 -: 6]),
      .data_o (rom_data)
   );

   assign note_ok = (note_q != '0) && (note_q < NOTE_W'(NUM_PITCHES));

   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      slot_d     = slot_q;
      note_d     = note_q;
      phase_d    = phase_q;
      done_d     = 1'b0;
      latch      = 1'b0;
      latch_note = note_q;
      inc        = note_ok ? PHASE_W'(PHASE_INC[note_q]) : '0;

      if (state_q == PLAY) begin
         if (tick_in) begin
            phase_d = phase_q + inc;
         end
         cyc_d = cyc_q + CYC_W'(1);
         if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            if (slot_q != SLOT_LAST) begin
               slot_d     = slot_q + 8'd1;
               latch      = 1'b1;
               latch_note = notes_in[slot_d[IDX_W-1:0]];
            end else if (loop_in) begin
               slot_d     = '0;
               latch      = 1'b1;
               latch_note = notes_in[0];
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
      end

      // Repeated notes are legato; only a pitch change restarts the waveform
      if (latch) begin
         note_d = latch_note;
         if (latch_note != note_q) begin
            phase_d = '0;
         end
      end

      if (stop_in) begin
         state_d = IDLE;
         done_d  = 1'b0;
         cyc_d   = cyc_q;
         slot_d  = slot_q;
         note_d  = note_q;
         phase_d = phase_q;
      end else if (start_in) begin
         state_d = PLAY;
         done_d  = 1'b0;
         cyc_d   = '0;
         slot_d  = '0;
         note_d  = notes_in[0];
         phase_d = '0;
      end

      mute_d  = (state_q != PLAY) || !note_ok || stop_in;
      valid_d = tick_q;
      amp_d   = amp_q;
      if (tick_q) begin
         amp_d = mute_q ? 8'sd0 : rom_data;
      end
      if (stop_in && (state_q == PLAY)) begin
         amp_d = 8'sd0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         slot_q  <= '0;
         note_q  <= '0;
         phase_q <= '0;
         done_q  <= 1'b0;
         tick_q  <= 1'b0;
         mute_q  <= 1'b1;
         amp_q   <= 8'sd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         slot_q  <= slot_d;
         note_q  <= note_d;
         phase_q <= phase_d;
         done_q  <= done_d;
         tick_q  <= tick_in;
         mute_q  <= mute_d;
         amp_q   <= amp_d;
         valid_q <= valid_d;
      end
   end

   assign amp_out       = amp_q;
   assign amp_valid_out = valid_q;
   assign playing_out   = (state_q == PLAY);
   assign slot_out      = slot_q;
   assign done_out      = done_q;

endmodule

// File: tb/tb_note_player.sv
// tb/tb_note_player.sv - scoreboard bench for note_player
module tb_note_player;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, start, stop, loop_l, tick;
   logic [3:0][5:0]   notes;
   logic signed [7:0] amp;
   logic              amp_v, playing, done;
   logic [7:0]        slot;

   logic              start2;
   logic [159:0][5:0] notes2;
   logic signed [7:0] amp2;
   logic              amp_v2, playing2, done2;
   logic [7:0]        slot2;

   note_player #(.NUM_SLOTS(4), .NOTE_W(6), .EIGHTH_CYCLES(10), .PHASE_W(16)) dut (
      .clk_in(clk), .rst_in(rst), .notes_in(notes), .start_in(start), .stop_in(stop),
      .loop_in(loop_l), .tick_in(tick), .amp_out(amp), .amp_valid_out(amp_v),
      .playing_out(playing), .slot_out(slot), .done_out(done)
   );

   note_player #(.EIGHTH_CYCLES(4)) dut_full (
      .clk_in(clk), .rst_in(rst), .notes_in(notes2), .start_in(start2), .stop_in(1'b0),
      .loop_in(1'b0), .tick_in(1'b0), .amp_out(amp2), .amp_valid_out(amp_v2),
      .playing_out(playing2), .slot_out(slot2), .done_out(done2)
   );

   typedef struct {
      int amp;
      int at;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   rise_cyc = 0;
   logic play_prev = 1'b0;
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int sine_ref(input int idx);
      return int'($floor(127.0 * $sin(2.0 * 3.14159265358979 * idx / 64.0) + 0.5));
   endfunction

   function automatic int inc_ref(input int n);
      return int'($floor(130.8128 * 65536.0 / 8467.0 * $pow(2.0, (n - 1) / 12.0) + 0.5));
   endfunction

   function automatic int sample_ref(input int n, input int k);
      return sine_ref(((k * inc_ref(n)) % 65536) >> 10);
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a sample
   always @(negedge clk) begin
      if (amp_v) begin
         if (q.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            mon_e = q.pop_front();
            check("amp", int'(amp), mon_e.amp);
            check("amp_latency", cyc, mon_e.at);
         end
      end
      if (playing && !play_prev) rise_cyc = cyc;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         check("done_playing_low", int'(playing), 0);
      end
      play_prev = playing;
   end

   task automatic step(input bit st, input bit sp, input bit tk, input int exp_amp);
      exp_t e;
      start = st;
      stop  = sp;
      tick  = tk;
      if (tk) begin
         e.amp = exp_amp;
         e.at  = cyc + 2;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      tick  = 1'b0;
   endtask

   int k;
   int exp_amp;
   bit tk;
   int full_len;
   int max_slot;
   int exp5c [6] = '{0, 0, 12, 25, 0, 12};
   int i5c;

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; loop_l = 1'b0; tick = 1'b1;
      start2 = 1'b0; notes = '0; notes2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_amp", int'(amp), 0);
      check("rst_valid", int'(amp_v), 0);
      check("rst_playing", int'(playing), 0);
      check("rst_slot", int'(slot), 0);
      check("rst_done", int'(done), 0);
      rst = 1'b0;
      tick = 1'b0;
      step(0, 0, 0, 0);

      // Tick while idle yields a zero sample
      step(0, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0);

      // Single sustained note, phase carried across slot boundaries
      for (int i = 0; i < 4; i++) notes[i] = 6'd1;
      step(1, 0, 0, 0);
      k = 0;
      for (int r = 1; r <= 45; r++) begin
         tk = (r % 3 == 1);
         exp_amp = (r <= 40) ? sample_ref(1, k) : 0;
         if (tk && r <= 40) k++;
         step(0, 0, tk, exp_amp);
      end
      check("single_done_count", done_cnt, 1);
      check("single_done_delay", done_cyc - rise_cyc, 40);

      // Rest, out-of-range, then a fresh note starting at phase 0
      notes[0] = 6'd0; notes[1] = 6'd50; notes[2] = 6'd2; notes[3] = 6'd0;
      step(1, 0, 0, 0);
      k = 0;
      for (int r = 1; r <= 42; r++) begin
         tk = (r % 2 == 1);
         exp_amp = 0;
         if (r <= 40 && (r - 1) / 10 == 2) begin
            exp_amp = sample_ref(2, k);
            if (tk) k++;
         end
         step(0, 0, tk, exp_amp);
      end
      check("rest_done_count", done_cnt, 2);

      // Looping wraps slot 3 to 0; stop mid-song silences output
      for (int i = 0; i < 4; i++) notes[i] = 6'd2;
      loop_l = 1'b1;
      step(1, 0, 0, 0);
      for (int r = 1; r <= 70; r++) begin
         if (r == 40) check("loop_slot_last", int'(slot), 3);
         if (r == 41) begin
            check("loop_slot_wrap", int'(slot), 0);
            check("loop_playing", int'(playing), 1);
         end
         if (r == 60) check("loop_amp_held", int'(amp), 12);
         if (r == 64) begin
            check("stop_playing", int'(playing), 0);
            check("stop_amp_zero", int'(amp), 0);
         end
         tk = (r == 52) || (r == 55) || (r == 66);
         exp_amp = (r == 55) ? 12 : 0;
         step(0, (r == 63), tk, exp_amp);
      end
      loop_l = 1'b0;
      check("loop_stop_no_done", done_cnt, 2);

      // Start and stop together stay idle
      step(1, 1, 0, 0);
      check("startstop_idle", int'(playing), 0);
      step(0, 0, 0, 0);
      check("startstop_idle2", int'(playing), 0);

      // Restart in slot 2 resets slot and cycle count
      for (int i = 0; i < 4; i++) notes[i] = 6'd1;
      step(1, 0, 0, 0);
      for (int r = 1; r <= 40; r++) begin
         if (r == 24) check("restart_pre_slot", int'(slot), 2);
         if (r == 26) begin
            check("restart_slot", int'(slot), 0);
            check("restart_playing", int'(playing), 1);
         end
         if (r == 35) check("restart_slot_hold", int'(slot), 0);
         if (r == 36) check("restart_slot_next", int'(slot), 1);
         step((r == 25), (r == 40), 0, 0);
      end
      check("restart_no_done", done_cnt, 2);

      // Tick on the boundary cycle uses the old note
      notes[0] = 6'd1; notes[1] = 6'd2; notes[2] = 6'd2; notes[3] = 6'd2;
      step(1, 0, 0, 0);
      i5c = 0;
      for (int r = 1; r <= 20; r++) begin
         tk = (r == 2) || (r == 5) || (r == 8) || (r == 10) || (r == 12) || (r == 14);
         exp_amp = 0;
         if (tk) begin
            exp_amp = exp5c[i5c];
            i5c++;
         end
         step(0, (r == 16), tk, exp_amp);
      end

      // Full-length song with default slot count
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      check("full_playing", int'(playing2), 1);
      full_len = -1;
      max_slot = 0;
      for (int r = 1; r <= 700; r++) begin
         if (int'(slot2) > max_slot) max_slot = int'(slot2);
         if (done2) begin
            full_len = r - 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("full_length", full_len, 640);
      check("full_max_slot", max_slot, 159);
      check("full_playing_end", int'(playing2), 0);

      repeat (4) @(posedge clk);
      #1;
      check("pending_samples", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
